fft_bfly_ctrl: RTL and testbench



---
 rtl/fft_bfly_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fft_bfly_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_ctrl.sv
// Address/enable sequencer for an in-place radix-2 DIT FFT over a shared butterfly and single RAM.
// Optional sticky error output enabled by defining FFT_BFLY_CTRL_ERR_EN.
module fft_bfly_ctrl #(
  parameter int N_LOG2   = 8,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 3,
  localparam int SW      = $clog2(N_LOG2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_p,
  output logic [N_LOG2-1:0] rd_addr_q,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bfly_en,
  input  logic              bfly_vld,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_p,
  output logic [N_LOG2-1:0] wr_addr_q
`ifdef FFT_BFLY_CTRL_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int DL  = RD_LAT + BFLY_LAT;
  localparam int OW  = $clog2(DL + 1);
  localparam int KW  = N_LOG2 - 1;
  localparam int SWE = SW + 1;
  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [N_LOG2-1:0] p;
    logic [N_LOG2-1:0] q;
  } dl_t;

  state_t            r_state, w_state_nx;
  logic [KW-1:0]     r_k, w_k_nx;
  logic [SW-1:0]     r_stage, w_stage_nx;
  logic [OW-1:0]     r_outst;
  logic              r_rd_en, r_last, r_busy, r_done;
  logic [N_LOG2-1:0] r_rd_addr_p, r_rd_addr_q;
  logic [KW-1:0]     r_tw_addr;
  logic [RD_LAT-1:0] r_en_sr;
  dl_t               r_dl [DL];
  dl_t               w_tail;
  logic              w_last_wr;

  logic [N_LOG2-1:0] w_kx, w_span, w_pos, w_p, w_q, w_tw_full;
  logic [SWE-1:0]    w_sh_p, w_sh_tw;

  assign w_tail    = r_dl[DL-1];
  assign w_last_wr = bfly_vld & w_tail.vld & w_tail.last;

  // Next-state and butterfly index/stage sequencing.
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_stage_nx = r_stage;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_RUN;
          w_k_nx     = {KW{1'b0}};
          w_stage_nx = {SW{1'b0}};
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_k == K_LAST) begin
          w_state_nx = ST_DRAIN;
        end else begin
          w_k_nx = r_k + KW'(1);
        end
      end
      ST_DRAIN: begin
        // Leave only once the tagged last write retires and nothing else is in flight.
        if (w_last_wr && (r_outst == OW'(1))) begin
          if (r_stage == LAST_STAGE) begin
            w_state_nx = ST_DONE;
          end else begin
            w_state_nx = ST_RUN;
            w_stage_nx = r_stage + SW'(1);
            w_k_nx     = {KW{1'b0}};
          end
        end else begin
          w_state_nx = ST_DRAIN;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Operand and twiddle addresses for the butterfly about to be issued.
  always_comb begin
    w_kx      = {1'b0, w_k_nx};
    w_span    = N_LOG2'(1) << w_stage_nx;
    w_pos     = w_kx & (w_span - N_LOG2'(1));
    w_sh_p    = {1'b0, w_stage_nx} + SWE'(1);
    w_sh_tw   = SWE'(N_LOG2 - 1) - {1'b0, w_stage_nx};
    w_p       = ((w_kx >> w_stage_nx) << w_sh_p) | w_pos;
    w_q       = w_p + w_span;
    w_tw_full = w_pos << w_sh_tw;
  end

  // FSM state, counters and registered issue-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= {KW{1'b0}};
      r_stage     <= {SW{1'b0}};
      r_rd_en     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_addr_p <= {N_LOG2{1'b0}};
      r_rd_addr_q <= {N_LOG2{1'b0}};
      r_tw_addr   <= {KW{1'b0}};
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_stage <= w_stage_nx;
      r_rd_en <= (w_state_nx == ST_RUN);
      r_last  <= (w_state_nx == ST_RUN) && (w_k_nx == K_LAST);
      r_busy  <= (w_state_nx == ST_RUN) || (w_state_nx == ST_DRAIN);
      r_done  <= (w_state_nx == ST_DONE);
      if (w_state_nx == ST_RUN) begin
        r_rd_addr_p <= w_p;
        r_rd_addr_q <= w_q;
        r_tw_addr   <= w_tw_full[KW-1:0];
      end else begin
        r_rd_addr_p <= {N_LOG2{1'b0}};
        r_rd_addr_q <= {N_LOG2{1'b0}};
        r_tw_addr   <= {KW{1'b0}};
      end
    end
  end

  // Read-to-butterfly enable delay and write-back address delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_sr <= {RD_LAT{1'b0}};
      for (int i = 0; i < DL; i++) begin
        r_dl[i] <= '0;
      end
    end else begin
      r_en_sr[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_en_sr[i] <= r_en_sr[i-1];
      end
      r_dl[0] <= '{vld: r_rd_en, last: r_last, p: r_rd_addr_p, q: r_rd_addr_q};
      for (int i = 1; i < DL; i++) begin
        r_dl[i] <= r_dl[i-1];
      end
    end
  end

  // Butterflies in flight between read issue and write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= {OW{1'b0}};
    end else begin
      case ({r_rd_en, bfly_vld})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

`ifdef FFT_BFLY_CTRL_ERR_EN
  logic r_err;

  // Sticky flag: pipeline valid out of step with the delay line, or start while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (bfly_vld != w_tail.vld) | (start & r_busy);
    end
  end

  assign err = r_err;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign stage     = r_stage;
  assign rd_en     = r_rd_en;
  assign rd_addr_p = r_rd_addr_p;
  assign rd_addr_q = r_rd_addr_q;
  assign tw_addr   = r_tw_addr;
  assign bfly_en   = r_en_sr[RD_LAT-1];
  assign wr_en     = bfly_vld;
  assign wr_addr_p = w_tail.p;
  assign wr_addr_q = w_tail.q;

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Directed bench for fft_bfly_ctrl with a RAM, twiddle ROM and 3-stage butterfly model.
module tb_fft_bfly_ctrl;

  localparam int AMP = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bfly_en, bfly_vld, wr_en;
  logic [2:0] stage;
  logic [7:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
  logic [6:0] tw_addr;
`ifdef FFT_BFLY_CTRL_ERR_EN
  logic       err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fft_bfly_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_p(rd_addr_p), .rd_addr_q(rd_addr_q), .tw_addr(tw_addr),
    .bfly_en(bfly_en), .bfly_vld(bfly_vld), .wr_en(wr_en),
    .wr_addr_p(wr_addr_p), .wr_addr_q(wr_addr_q)
`ifdef FFT_BFLY_CTRL_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic real tcos(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // W_256^k in Q14: re = cos(2*pi*k/256), im = -sin(2*pi*k/256)
  function automatic int tw_re(input logic [6:0] k);
    return int'(tcos(6.283185307179586 * real'(k) / 256.0) * 16384.0);
  endfunction

  function automatic int tw_im(input logic [6:0] k);
    return -int'(tcos(6.283185307179586 * real'(k) / 256.0 - 1.5707963267948966) * 16384.0);
  endfunction

  function automatic int t_re(input logic [6:0] k, input int xr, input int xi);
    return (tw_re(k) * xr - tw_im(k) * xi) >>> 14;
  endfunction

  function automatic int t_im(input logic [6:0] k, input int xr, input int xi);
    return (tw_re(k) * xi + tw_im(k) * xr) >>> 14;
  endfunction

  int         ram_re [256];
  int         ram_im [256];
  int         xp_re, xp_im, xq_re, xq_im;
  logic [6:0] tw_q;
  int         pr [3];
  int         pim [3];
  int         qr [3];
  int         qim [3];
  logic [2:0] pv;

  assign bfly_vld = pv[2];

  // RAM (1-cycle read), twiddle ROM and a butterfly scaling by 1/2 per stage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        ram_re[i] <= (i == 0) ? AMP : 0;
        ram_im[i] <= 0;
      end
      pv <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        pr[i] <= 0; pim[i] <= 0; qr[i] <= 0; qim[i] <= 0;
      end
      xp_re <= 0; xp_im <= 0; xq_re <= 0; xq_im <= 0; tw_q <= 7'd0;
    end else begin
      if (rd_en) begin
        xp_re <= ram_re[rd_addr_p]; xp_im <= ram_im[rd_addr_p];
        xq_re <= ram_re[rd_addr_q]; xq_im <= ram_im[rd_addr_q];
        tw_q  <= tw_addr;
      end
      pv     <= {pv[1:0], bfly_en};
      pr[0]  <= (xp_re + t_re(tw_q, xq_re, xq_im)) >>> 1;
      pim[0] <= (xp_im + t_im(tw_q, xq_re, xq_im)) >>> 1;
      qr[0]  <= (xp_re - t_re(tw_q, xq_re, xq_im)) >>> 1;
      qim[0] <= (xp_im - t_im(tw_q, xq_re, xq_im)) >>> 1;
      for (int i = 1; i < 3; i++) begin
        pr[i] <= pr[i-1]; pim[i] <= pim[i-1]; qr[i] <= qr[i-1]; qim[i] <= qim[i-1];
      end
      if (wr_en) begin
        ram_re[wr_addr_p] <= pr[2]; ram_im[wr_addr_p] <= pim[2];
        ram_re[wr_addr_q] <= qr[2]; ram_im[wr_addr_q] <= qim[2];
      end
    end
  end

  int tc  [7] = '{1, 2, 3, 133, 134, 406, 926};
  int tpp [7] = '{0, 2, 4, 0, 1, 17, 1};
  int tqq [7] = '{1, 3, 5, 2, 3, 25, 129};
  int ttw [7] = '{0, 0, 0, 0, 64, 16, 1};

  initial begin
    int   rd_cnt, wr_cnt, done_cnt, c, done_at;
    logic exp_rd, prev_rd;
    int   q_c [$];
    int   q_p [$];
    int   q_q [$];
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; prev_rd = 1'b0; done_at = -1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_stage", stage, 0);
    chk("rst_bfly_en", bfly_en, 0);
    chk("rst_wr_en", wr_en, 0);
    rst_n = 1'b1;

    // Full run; extra start pulses at cycles 50 and 600 must be ignored.
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 1065; cyc++) begin
      @(posedge clk); #1;
      start  = (cyc == 50) || (cyc == 600);
      exp_rd = ((cyc - 1) / 132 < 8) && ((cyc - 1) % 132 < 128);
      chk("rd_en", rd_en, exp_rd);
      chk("bfly_en", bfly_en, prev_rd);
      prev_rd = exp_rd;
      chk("busy", busy, (cyc <= 1056));
      chk("done", done, (cyc == 1057));
      if (cyc <= 1056) chk("stage", stage, (cyc - 1) / 132);
`ifdef FFT_BFLY_CTRL_ERR_EN
      chk("err", err, (cyc >= 51));
`endif
      for (int j = 0; j < 7; j++) begin
        if (cyc == tc[j]) begin
          chk("addr_p", rd_addr_p, tpp[j]);
          chk("addr_q", rd_addr_q, tqq[j]);
          chk("tw_addr", tw_addr, ttw[j]);
        end
      end
      if (done) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        q_c.push_back(cyc); q_p.push_back(rd_addr_p); q_q.push_back(rd_addr_q);
      end
      if (wr_en) begin
        wr_cnt++;
        chk("wr_pending", (q_c.size() != 0), 1);
        if (q_c.size() != 0) begin
          c = q_c.pop_front();
          chk("wr_latency", cyc - c, 4);
          chk("wr_addr_p", wr_addr_p, q_p.pop_front());
          chk("wr_addr_q", wr_addr_q, q_q.pop_front());
        end
      end
    end
    chk("rd_count", rd_cnt, 1024);
    chk("wr_count", wr_cnt, 1024);
    chk("done_count", done_cnt, 1);
    for (int i = 0; i < 256; i++) begin
      chk("fft_re", ram_re[i], AMP / 256);
      chk("fft_im", ram_im[i], 0);
    end

    // Abort at cycle 300 of a second run.
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stage", stage, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_addr_p", rd_addr_p, 0);
    chk("abort_rd_addr_q", rd_addr_q, 0);
    chk("abort_tw_addr", tw_addr, 0);
    chk("abort_bfly_en", bfly_en, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_addr_p", wr_addr_p, 0);
    chk("abort_wr_addr_q", wr_addr_q, 0);
`ifdef FFT_BFLY_CTRL_ERR_EN
    chk("abort_err", err, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done, 0);
    rst_n = 1'b1;

    // Clean restart: done exactly 1057 cycles after start.
    @(posedge clk); #1;
    start = 1'b1;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
    end
    chk("restart_done_at", done_at, 1057);
    chk("restart_done_count", done_cnt, 1);
    for (int i = 0; i < 256; i += 37) begin
      chk("restart_fft_re", ram_re[i], AMP / 256);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
